morse_key_decoder: RTL
======================

// Module: morse_key_decoder
// PURPOSE
//  Receive side of the Morse letter path: timestamps a debounced key, classifies each press as
//  dot or dash, and on an inter-letter gap emits a letter as {size, pattern}.
//  The output encoding matches what the transmit-side size/pattern registers load, so a decoded
//  letter can be fed straight back for blinking. Sits between the KEY debouncer and display/echo logic.
// PARAMETERS
//  TICK_DIV    25_000_000  clk cycles per time unit (0.5 s at 50 MHz)
//  DASH_UNITS  2           press of >= DASH_UNITS units is a dash, shorter is a dot
//  GAP_UNITS   3           continuous release of GAP_UNITS units ends the letter
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  reset    in   1  asynchronous, active-high; clears all state and outputs
//  key_in   in   1  debounced key, 1 = pressed; asynchronous to clk
//  valid    out  1  one-cycle pulse: size/pattern/error updated this cycle
//  size     out  3  number of symbols in letter, 1..4 (0 on error)
//  pattern  out  4  bit i = symbol i (bit0 first), 1 = dash, 0 = dot; unused bits 0
//  error    out  1  letter had more than 4 symbols; qualified by valid
// BEHAVIOUR
//  - Reset: valid=0, size=0, pattern=0, error=0, state=IDLE, counters=0, sync flops=0.
//  - key_in passes a 2-flop synchronizer -> key_s; all timing uses key_s (2-cycle input latency).
//  - Cycle counter cyc counts to TICK_DIV*max(DASH_UNITS,GAP_UNITS); it clears on every state
//    entry and saturates at its maximum.
//  - FSM:
//    IDLE : sym_cnt=0, shift=0, ovf=0. key_s=1 -> PRESS.
//    PRESS: key_s=0 -> record symbol: dash iff cyc >= DASH_UNITS*TICK_DIV; if sym_cnt<4 write
//           bit[sym_cnt], sym_cnt++; else ovf=1. -> GAP.
//    GAP  : key_s=1 with cyc < GAP_UNITS*TICK_DIV -> PRESS (same letter);
//           cyc reaches GAP_UNITS*TICK_DIV-1 with key_s=0 -> EMIT.
//    EMIT : valid=1; if ovf: error=1, size=0, pattern=0; else error=0, size=sym_cnt,
//           pattern=shift. -> IDLE. (EMIT is a registered-output cycle.)
//  - size/pattern/error hold their last value until the next EMIT; valid is exactly one cycle.
//  - Presses shorter than one unit are dots (no glitch filtering; input is debounced).
//  - A key press arriving in the EMIT cycle is seen in IDLE the next cycle (no press is lost,
//    since key_s stays high).
//  - Reset mid-letter discards the partial letter; no valid is produced.
//  - Gap on the exact cycle boundary: a press seen while cyc == GAP_UNITS*TICK_DIV-1 continues
//    the letter (press takes priority over gap expiry).
// CONFIGURATION
//  MORSE_ASCII_EN defined: adds output ascii[7:0], registered with valid, from an A-Z lookup on
//    {size,pattern}. A pattern not in the table gives ascii=8'h3F ('?') and forces error=1.
//    Overflow also gives 8'h3F.
//  MORSE_ASCII_EN undefined: no ascii port, no table; error is set only by overflow.
// TESTING (TICK_DIV=4, DASH_UNITS=2, GAP_UNITS=3; dot = 4-cycle press, dash = 12-cycle press,
//   intra-gap = 4 cycles)
//  1. dot, dash, release 20 cycles -> one valid pulse: size=3'd2, pattern=4'b0010, error=0 ('A').
//  2. four dots -> size=4, pattern=4'b0000 ('H'). Then dash alone -> size=1, pattern=4'b0001 ('T').
//  3. five dots -> valid with error=1, size=0, pattern=0; the next letter decodes normally.
//  4. Boundaries, each run as a one-symbol letter:
//     - press of 7 cycles (cyc=7) -> dot;
//     - press of 8 cycles -> dash;
//     - release of 11 cycles, then press -> symbol joins the previous letter.
//  5. reset pulse during the PRESS of a 3rd symbol -> all outputs 0, no valid;
//     then one dot -> size=1, pattern=0 ('E').
//  6. With MORSE_ASCII_EN: 'A' -> ascii=8'h41; dash x4 (not in table) -> ascii=8'h3F, error=1.
//     Without the macro: the same dash x4 -> error=0, size=4, pattern=4'b1111.

Source files
------------

// File: rtl/morse_key_decoder.sv
// morse_key_decoder: receive side of the Morse letter path.
// Synchronises a debounced key and times each press and release. Each press is
// classified as a dot or a dash, and an inter-letter gap emits the letter as
// {size, pattern}, using the same encoding the transmit side loads.
// Optional feature macro: MORSE_ASCII_EN adds a registered ascii output from an A-Z lookup.
module morse_key_decoder #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned DASH_UNITS = 2,
    parameter int unsigned GAP_UNITS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_in,
    output logic       valid,
    output logic [2:0] size,
    output logic [3:0] pattern,
    output logic       error
`ifdef MORSE_ASCII_EN
    ,
    output logic [7:0] ascii
`endif
);

    localparam int unsigned MAX_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int unsigned CYC_MAX   = TICK_DIV * MAX_UNITS;
    localparam int unsigned CW        = $clog2(CYC_MAX + 1);
    localparam logic [CW-1:0] CYC_SAT  = CW'(CYC_MAX);
    localparam logic [CW-1:0] DASH_LIM = CW'(DASH_UNITS * TICK_DIV);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_UNITS * TICK_DIV - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, key_s_q;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [2:0]      sym_cnt_q, sym_cnt_d;
    logic [3:0]      shift_q, shift_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [2:0]      size_q, size_d;
    logic [3:0]      pattern_q, pattern_d;
    logic            error_q, error_d;
`ifdef MORSE_ASCII_EN
    logic [7:0]      ascii_q, ascii_d;
    logic [7:0]      lookup_s;

    // A-Z table on {size, pattern}; 8'h00 marks a pattern that is not a letter.
    function automatic logic [7:0] morse_to_ascii(input logic [2:0] sz, input logic [3:0] pat);
        logic [7:0] ch;
        case ({sz, pat})
            {3'd1, 4'b0000}: ch = 8'h45; // E
            {3'd1, 4'b0001}: ch = 8'h54; // T
            {3'd2, 4'b0010}: ch = 8'h41; // A
            {3'd2, 4'b0000}: ch = 8'h49; // I
            {3'd2, 4'b0011}: ch = 8'h4D; // M
            {3'd2, 4'b0001}: ch = 8'h4E; // N
            {3'd3, 4'b0001}: ch = 8'h44; // D
            {3'd3, 4'b0011}: ch = 8'h47; // G
            {3'd3, 4'b0101}: ch = 8'h4B; // K
            {3'd3, 4'b0111}: ch = 8'h4F; // O
            {3'd3, 4'b0010}: ch = 8'h52; // R
            {3'd3, 4'b0000}: ch = 8'h53; // S
            {3'd3, 4'b0100}: ch = 8'h55; // U
            {3'd3, 4'b0110}: ch = 8'h57; // W
            {3'd4, 4'b0001}: ch = 8'h42; // B
            {3'd4, 4'b0101}: ch = 8'h43; // C
            {3'd4, 4'b0100}: ch = 8'h46; // F
            {3'd4, 4'b0000}: ch = 8'h48; // H
            {3'd4, 4'b1110}: ch = 8'h4A; // J
            {3'd4, 4'b0010}: ch = 8'h4C; // L
            {3'd4, 4'b0110}: ch = 8'h50; // P
            {3'd4, 4'b1011}: ch = 8'h51; // Q
            {3'd4, 4'b1000}: ch = 8'h56; // V
            {3'd4, 4'b1001}: ch = 8'h58; // X
            {3'd4, 4'b1101}: ch = 8'h59; // Y
            {3'd4, 4'b0011}: ch = 8'h5A; // Z
            default:         ch = 8'h00;
        endcase
        return ch;
    endfunction

    assign lookup_s = morse_to_ascii(sym_cnt_q, shift_q);
    assign ascii    = ascii_q;
`endif

    assign valid   = valid_q;
    assign size    = size_q;
    assign pattern = pattern_q;
    assign error   = error_q;

    // Two-flop synchroniser for the asynchronous key input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            key_s_q <= 1'b0;
        end else begin
            sync1_q <= key_in;
            key_s_q <= sync1_q;
        end
    end

    // Cycle counter. The cycle that decides a transition is cycle 0 of the new state,
    // so the first cycle spent in it reads 1 and cyc equals key_s samples since the edge.
    always_comb begin
        cyc_d = cyc_q;
        if (state_d != state_q) begin
            cyc_d = CYC_ONE;
        end else if (cyc_q == CYC_SAT) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + CYC_ONE;
        end
    end

    // Next-state, letter assembly and output-load logic.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        shift_d   = shift_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        size_d    = size_q;
        pattern_d = pattern_q;
        error_d   = error_q;
`ifdef MORSE_ASCII_EN
        ascii_d   = ascii_q;
`endif
        case (state_q)
            S_IDLE: begin
                sym_cnt_d = 3'd0;
                shift_d   = 4'd0;
                ovf_d     = 1'b0;
                if (key_s_q) begin
                    state_d = S_PRESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESS: begin
                if (!key_s_q) begin
                    state_d = S_GAP;
                    if (sym_cnt_q < 3'd4) begin
                        shift_d[sym_cnt_q[1:0]] = (cyc_q >= DASH_LIM);
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d = S_PRESS;
                end
            end
            S_GAP: begin
                // A press on the last gap cycle still belongs to this letter.
                if (key_s_q) begin
                    state_d = S_PRESS;
                end else if (cyc_q >= GAP_LAST) begin
                    state_d = S_EMIT;
                    valid_d = 1'b1;
                    if (ovf_q) begin
                        error_d   = 1'b1;
                        size_d    = 3'd0;
                        pattern_d = 4'd0;
`ifdef MORSE_ASCII_EN
                        ascii_d   = 8'h3F;
`endif
                    end else begin
                        error_d   = 1'b0;
                        size_d    = sym_cnt_q;
                        pattern_d = shift_q;
`ifdef MORSE_ASCII_EN
                        if (lookup_s == 8'h00) begin
                            ascii_d = 8'h3F;
                            error_d = 1'b1;
                        end else begin
                            ascii_d = lookup_s;
                        end
`endif
                    end
                end else begin
                    state_d = S_GAP;
                end
            end
            S_EMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            sym_cnt_q <= 3'd0;
            shift_q   <= 4'd0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            size_q    <= 3'd0;
            pattern_q <= 4'd0;
            error_q   <= 1'b0;
`ifdef MORSE_ASCII_EN
            ascii_q   <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            sym_cnt_q <= sym_cnt_d;
            shift_q   <= shift_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            size_q    <= size_d;
            pattern_q <= pattern_d;
            error_q   <= error_d;
`ifdef MORSE_ASCII_EN
            ascii_q   <= ascii_d;
`endif
        end
    end

endmodule
